// File: rtl/matmul_sp_readback.sv
// ----------------------------------------------------------------------------
// matmul_sp_readback
//
// APB master that reads a rows x cols result matrix out of the matmul
// accelerator scratchpad, one element per APB read, in row-major order.
//   compare mode (mode=0): each element is checked against an expected-value
//                          stream; mismatches are counted and the first one
//                          is located.
//   dump mode    (mode=1): each element is forwarded on an output stream.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   start_i                start pulse (honoured only when idle)
//   mode_i, sp_sel_i       mode and SP bank, latched at start
//   rows_i, cols_i         matrix dimensions, latched at start
//   psel_o .. pwdata_o     APB request side (read-only master)
//   prdata_i, pready_i,
//   pslverr_i              APB response side
//   exp_data_i/valid/ready expected-value stream (compare mode)
//   rd_data_o/valid/ready  element stream (dump mode)
//   busy_o, done_o         activity and one-cycle completion pulse
//   slverr_o, timeout_o    abort reasons of the last run
//   err_cnt_o              saturating mismatch count
//   first_err_idx_o/vld_o  {sp_sel,row,col} of the first mismatch
// ----------------------------------------------------------------------------
module matmul_sp_readback #(
  parameter int         BUS_WIDTH   = 32,
  parameter int         ADDR_WIDTH  = 32,
  parameter int         DATA_WIDTH  = 32,
  parameter int         MAX_DIM     = 4,
  parameter int         SP_NTARGETS = 4,
  parameter logic [4:0] SP_ADDR     = 5'b10000,
  parameter int         TIMEOUT     = 64,
  parameter int         ERRCNT_W    = 16,
  localparam int        SEL_W       = $clog2(SP_NTARGETS),
  localparam int        POS_W       = $clog2(MAX_DIM),
  localparam int        DIM_W       = POS_W + 1,
  localparam int        IDX_W       = SEL_W + 2 * POS_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [SEL_W-1:0]      sp_sel_i,
  input  logic [DIM_W-1:0]      rows_i,
  input  logic [DIM_W-1:0]      cols_i,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [DATA_WIDTH-1:0] exp_data_i,
  input  logic                  exp_valid_i,
  output logic                  exp_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  slverr_o,
  output logic                  timeout_o,
  output logic [ERRCNT_W-1:0]   err_cnt_o,
  output logic [IDX_W-1:0]      first_err_idx_o,
  output logic                  first_err_vld_o
);

  localparam int               TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_CHECK,
    S_DONE
  } state_t;

  // Mismatch counter sticks at all-ones instead of wrapping.
  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                r_state;
  state_t                w_next;

  logic                  r_mode;
  logic [SEL_W-1:0]      r_sel;
  logic [DIM_W-1:0]      r_rows;
  logic [DIM_W-1:0]      r_cols;
  logic [POS_W-1:0]      r_row;
  logic [POS_W-1:0]      r_col;
  logic [DATA_WIDTH-1:0] r_data;
  logic [TO_W-1:0]       r_to_cnt;
  logic [ERRCNT_W-1:0]   r_err_cnt;
  logic [IDX_W-1:0]      r_first_idx;
  logic                  r_first_vld;
  logic                  r_slverr;
  logic                  r_timeout;

  logic                  w_psel;
  logic                  w_penable;
  logic                  w_exp_ready;
  logic                  w_rd_valid;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_set_slverr;
  logic                  w_set_timeout;
  logic                  w_elem_done;
  logic                  w_dims_bad;
  logic                  w_last_col;
  logic                  w_last_row;
  logic                  w_last;
  logic                  w_mismatch;
  logic [IDX_W-1:0]      w_idx;
  logic [ADDR_WIDTH-1:0] w_paddr;

  assign w_dims_bad = (rows_i == '0) || (cols_i == '0) ||
                      (rows_i > DIM_MAX) || (cols_i > DIM_MAX);

  // Position compares are done one bit wider so a full-size dimension
  // (MAX_DIM) still fits next to the narrower row/col counters.
  assign w_last_col = ({1'b0, r_col} == (r_cols - DIM_W'(1)));
  assign w_last_row = ({1'b0, r_row} == (r_rows - DIM_W'(1)));
  assign w_last     = w_last_col && w_last_row;
  assign w_idx      = {r_sel, r_row, r_col};

  // Only compare mode ever counts; the dump handshake never touches it.
  assign w_mismatch = w_elem_done && !r_mode && (r_data != exp_data_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_psel        = 1'b0;
    w_penable     = 1'b0;
    w_exp_ready   = 1'b0;
    w_rd_valid    = 1'b0;
    w_busy        = 1'b1;
    w_done        = 1'b0;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_set_slverr  = 1'b0;
    w_set_timeout = 1'b0;
    w_elem_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start_i) begin
          w_accept = 1'b1;
          w_next   = w_dims_bad ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: begin
        w_psel = 1'b1;
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (pready_i) begin
          if (pslverr_i) begin
            w_set_slverr = 1'b1;
            w_next       = S_DONE;
          end else begin
            w_capture = 1'b1;
            w_next    = S_CHECK;
          end
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_set_timeout = 1'b1;
          w_next        = S_DONE;
        end
      end
      S_CHECK: begin
        if (!r_mode) begin
          w_exp_ready = 1'b1;
          w_elem_done = exp_valid_i;
        end else begin
          w_rd_valid  = 1'b1;
          w_elem_done = rd_ready_i;
        end
        if (w_elem_done) begin
          w_next = w_last ? S_DONE : S_SETUP;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Address is driven only while the transfer is selected so the bus idles
  // at zero; it is a function of registered state, hence stable from SETUP
  // through the end of ACCESS.
  always_comb begin
    w_paddr = '0;
    if (w_psel) begin
      w_paddr[4:0]        = SP_ADDR;
      w_paddr[5 +: IDX_W] = w_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mode      <= 1'b0;
      r_sel       <= '0;
      r_rows      <= '0;
      r_cols      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_data      <= '0;
      r_to_cnt    <= '0;
      r_err_cnt   <= '0;
      r_first_idx <= '0;
      r_first_vld <= 1'b0;
      r_slverr    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode      <= mode_i;
        r_sel       <= sp_sel_i;
        r_rows      <= rows_i;
        r_cols      <= cols_i;
        r_row       <= '0;
        r_col       <= '0;
        r_err_cnt   <= '0;
        r_first_idx <= '0;
        r_first_vld <= 1'b0;
        r_slverr    <= 1'b0;
        r_timeout   <= 1'b0;
      end

      // Wait-state counter restarts for every transfer.
      if (r_state == S_SETUP) begin
        r_to_cnt <= '0;
      end else if ((r_state == S_ACCESS) && !pready_i) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_capture) begin
        r_data <= prdata_i[DATA_WIDTH-1:0];
      end
      if (w_set_slverr) begin
        r_slverr <= 1'b1;
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end

      if (w_mismatch) begin
        r_err_cnt <= sat_inc(r_err_cnt);
        if (!r_first_vld) begin
          r_first_vld <= 1'b1;
          r_first_idx <= w_idx;
        end
      end

      if (w_elem_done) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign psel_o          = w_psel;
  assign penable_o       = w_penable;
  assign pwrite_o        = 1'b0;
  assign paddr_o         = w_paddr;
  assign pstrb_o         = '0;
  assign pwdata_o        = '0;
  assign exp_ready_o     = w_exp_ready;
  assign rd_data_o       = r_data;
  assign rd_valid_o      = w_rd_valid;
  assign busy_o          = w_busy;
  assign done_o          = w_done;
  assign slverr_o        = r_slverr;
  assign timeout_o       = r_timeout;
  assign err_cnt_o       = r_err_cnt;
  assign first_err_idx_o = r_first_idx;
  assign first_err_vld_o = r_first_vld;

endmodule

// File: tb/tb_matmul_sp_readback.sv
// ----------------------------------------------------------------------------
// Directed bench for matmul_sp_readback: an APB slave model with configurable
// wait states / error / no-response, an expected-value source and a dump sink
// with configurable backpressure, all driven on the falling edge.
// ----------------------------------------------------------------------------
module tb_matmul_sp_readback;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [1:0]  sp_sel_i = '0;
  logic [2:0]  rows_i = '0;
  logic [2:0]  cols_i = '0;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o;
  logic [3:0]  pstrb_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;
  logic [31:0] exp_data_i = '0;
  logic        exp_valid_i = 1'b0;
  logic        exp_ready_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b0;
  logic        busy_o, done_o, slverr_o, timeout_o;
  logic [15:0] err_cnt_o;
  logic [5:0]  first_err_idx_o;
  logic        first_err_vld_o;

  matmul_sp_readback dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .sp_sel_i(sp_sel_i), .rows_i(rows_i), .cols_i(cols_i),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pstrb_o(pstrb_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .exp_data_i(exp_data_i), .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .busy_o(busy_o), .done_o(done_o), .slverr_o(slverr_o), .timeout_o(timeout_o),
    .err_cnt_o(err_cnt_o), .first_err_idx_o(first_err_idx_o),
    .first_err_vld_o(first_err_vld_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // APB slave model state
  logic [31:0] slv_data [16];
  logic [31:0] addr_log [16];
  logic [31:0] setup_addr = '0;
  int  rd_cnt = 0, wcnt = 0, slv_wait = 0, slv_err_at = 0;
  bit  slv_never = 1'b0;
  int  apb_bad = 0, mode_bad = 0;
  bit  cur_mode = 1'b0;

  // expected stream / dump sink state
  logic [31:0] exp_mem [16];
  logic [31:0] dump_log [16];
  int  exp_n = 0, exp_ptr = 0, dump_n = 0, bp_len = 0, bp_cnt = 0;
  bit  exp_take = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (psel_o && !penable_o) begin
      if (rd_cnt < 16) addr_log[rd_cnt] = paddr_o;
      rd_cnt++;
      wcnt = 0;
      setup_addr = paddr_o;
      pready_i = 1'b0;
      pslverr_i = 1'b0;
    end else if (psel_o && penable_o) begin
      if (paddr_o !== setup_addr || pwrite_o !== 1'b0) apb_bad++;
      if (!slv_never && wcnt >= slv_wait) begin
        pready_i  = 1'b1;
        prdata_i  = slv_data[(rd_cnt > 0 && rd_cnt <= 16) ? rd_cnt - 1 : 0];
        pslverr_i = (rd_cnt == slv_err_at);
      end else begin
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        wcnt++;
      end
    end else begin
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
    end
    if (penable_o && !psel_o) apb_bad++;
    if (exp_ready_o && (cur_mode != 1'b0 || psel_o)) mode_bad++;
    if (rd_valid_o && (cur_mode != 1'b1 || psel_o)) mode_bad++;
  end

  // Expected source: valid whenever data remains, so early data waits.
  always @(negedge clk) begin
    if (exp_take) exp_ptr++;
    exp_valid_i = (exp_ptr < exp_n);
    exp_data_i  = exp_valid_i ? exp_mem[exp_ptr] : '0;
    exp_take    = exp_valid_i && exp_ready_o;
  end

  // Dump sink: holds ready low for bp_len cycles of each valid element.
  always @(negedge clk) begin
    if (rd_valid_o) begin
      if (bp_cnt >= bp_len) begin
        rd_ready_i = 1'b1;
        if (dump_n < 16) dump_log[dump_n] = rd_data_o;
        dump_n++;
        bp_cnt = 0;
      end else begin
        rd_ready_i = 1'b0;
        bp_cnt++;
      end
    end else begin
      rd_ready_i = 1'b0;
      bp_cnt = 0;
    end
  end

  task automatic prep();
    @(posedge clk);
    #1;
    rd_cnt = 0; exp_ptr = 0; exp_take = 1'b0; exp_n = 0;
    dump_n = 0; bp_cnt = 0;
  endtask

  // Starts one run and follows it until one cycle after done_o.
  // cyc counts cycles from the start cycle to the done cycle, inclusive.
  task automatic run_op(input bit md, input logic [1:0] sel, input logic [2:0] r,
                        input logic [2:0] c, input bit poke,
                        output int cyc, output int acc, output int pc,
                        output int dc, output int fp);
    bit seen, fin;
    cyc = 0; acc = 0; pc = 0; dc = 0; fp = -1; seen = 1'b0; fin = 1'b0;
    cur_mode = md;
    @(negedge clk);
    mode_i = md; sp_sel_i = sel; rows_i = r; cols_i = c; start_i = 1'b1;
    for (int k = 1; k <= 2000 && !fin; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
      if (poke && k == 4) begin start_i = 1'b1; mode_i = ~md; rows_i = 3'd1; end
      if (poke && k == 5) start_i = 1'b0;
      if (psel_o) begin pc++; if (fp < 0) fp = k; end
      if (psel_o && penable_o) acc++;
      if (done_o) begin
        dc++;
        if (!seen) begin seen = 1'b1; cyc = k + 1; end
      end else if (seen) begin
        fin = 1'b1;
      end
    end
    chk("op_done_seen", seen, 1);
  endtask

  initial begin
    int cyc, acc, pc, dc, fp;
    bit found;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {psel_o, penable_o, pwrite_o, busy_o, done_o, slverr_o, timeout_o,
                     first_err_vld_o, rd_valid_o, exp_ready_o}, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_errcnt", err_cnt_o, 0);
    chk("rst_rddata", rd_data_o, 0);
    rst_i = 1'b0;

    // ---- compare, no mismatch: 2x2, sel=1 ----
    prep();
    for (int i = 0; i < 4; i++) begin slv_data[i] = 32'd5 + i; exp_mem[i] = 32'd5 + i; end
    exp_n = 4;
    run_op(1'b0, 2'd1, 3'd2, 3'd2, 1'b0, cyc, acc, pc, dc, fp);
    chk("t1_cycles", cyc, 14);
    chk("t1_first_psel", fp, 1);
    chk("t1_reads", rd_cnt, 4);
    chk("t1_addr0", addr_log[0], 32'h210);
    chk("t1_addr1", addr_log[1], 32'h230);
    chk("t1_addr2", addr_log[2], 32'h290);
    chk("t1_addr3", addr_log[3], 32'h2B0);
    chk("t1_errcnt", err_cnt_o, 0);
    chk("t1_first_vld", first_err_vld_o, 0);
    chk("t1_done_pulses", dc, 1);
    chk("t1_busy_after", busy_o, 0);
    chk("t1_exp_consumed", exp_ptr, 4);

    // ---- compare with mismatches at elements 4 and 7, start poked mid-run ----
    prep();
    for (int i = 0; i < 9; i++) begin slv_data[i] = 32'd10 + i; exp_mem[i] = 32'd10 + i; end
    exp_mem[3] = 32'hBAD; exp_mem[6] = 32'hBAD;
    exp_n = 9;
    run_op(1'b0, 2'd2, 3'd3, 3'd3, 1'b1, cyc, acc, pc, dc, fp);
    chk("t2_cycles", cyc, 29);
    chk("t2_reads", rd_cnt, 9);
    chk("t2_errcnt", err_cnt_o, 2);
    chk("t2_first_vld", first_err_vld_o, 1);
    chk("t2_first_idx", first_err_idx_o, 6'd36);
    repeat (3) @(negedge clk);
    chk("t2_errcnt_hold", err_cnt_o, 2);

    // ---- dump 1x4 with 3 cycles of backpressure per element ----
    prep();
    for (int i = 0; i < 4; i++) slv_data[i] = 32'hA1 + i;
    bp_len = 3;
    run_op(1'b1, 2'd3, 3'd1, 3'd4, 1'b0, cyc, acc, pc, dc, fp);
    chk("t3_cycles", cyc, 26);
    chk("t3_dump_count", dump_n, 4);
    for (int i = 0; i < 4; i++) chk("t3_dump_data", dump_log[i], 32'hA1 + i);
    chk("t3_errcnt_cleared", err_cnt_o, 0);
    chk("t3_first_vld_cleared", first_err_vld_o, 0);
    bp_len = 0;

    // ---- 5 wait states, 2x1 compare ----
    prep();
    slv_data[0] = 32'h1234_5678; slv_data[1] = 32'hDEAD_BEEF;
    exp_mem[0]  = 32'h1234_5678; exp_mem[1]  = 32'hDEAD_BEEF;
    exp_n = 2; slv_wait = 5;
    run_op(1'b0, 2'd0, 3'd2, 3'd1, 1'b0, cyc, acc, pc, dc, fp);
    chk("t4_cycles", cyc, 18);
    chk("t4_access_cycles", acc, 12);
    chk("t4_errcnt", err_cnt_o, 0);
    chk("t4_timeout", timeout_o, 0);
    slv_wait = 0;

    // ---- slave never ready: timeout after 64 ACCESS cycles ----
    prep();
    slv_never = 1'b1;
    run_op(1'b0, 2'd1, 3'd1, 3'd1, 1'b0, cyc, acc, pc, dc, fp);
    chk("t5_access_cycles", acc, 64);
    chk("t5_cycles", cyc, 67);
    chk("t5_timeout", timeout_o, 1);
    chk("t5_slverr", slverr_o, 0);
    chk("t5_done_pulses", dc, 1);
    slv_never = 1'b0;

    // ---- slave error on element 2 ----
    prep();
    for (int i = 0; i < 4; i++) begin slv_data[i] = 32'd1 + i; exp_mem[i] = 32'd1 + i; end
    exp_n = 4; slv_err_at = 2;
    run_op(1'b0, 2'd1, 3'd2, 3'd2, 1'b0, cyc, acc, pc, dc, fp);
    chk("t6_slverr", slverr_o, 1);
    chk("t6_timeout_cleared", timeout_o, 0);
    chk("t6_reads", rd_cnt, 2);
    chk("t6_cycles", cyc, 7);
    chk("t6_done_pulses", dc, 1);
    slv_err_at = 0;

    // ---- degenerate dimensions ----
    prep();
    run_op(1'b0, 2'd0, 3'd0, 3'd2, 1'b0, cyc, acc, pc, dc, fp);
    chk("t7_rows0_cycles", cyc, 2);
    chk("t7_rows0_psel", pc, 0);
    chk("t7_slverr_cleared", slverr_o, 0);
    prep();
    run_op(1'b0, 2'd0, 3'd5, 3'd1, 1'b0, cyc, acc, pc, dc, fp);
    chk("t7_rows5_cycles", cyc, 2);
    chk("t7_rows5_psel", pc, 0);

    // ---- reset in ACCESS, then clean restart ----
    prep();
    for (int i = 0; i < 4; i++) slv_data[i] = 32'd9;
    slv_wait = 3;
    cur_mode = 1'b0;
    @(negedge clk);
    mode_i = 1'b0; sp_sel_i = 2'd2; rows_i = 3'd2; cols_i = 3'd2; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (psel_o && penable_o) found = 1'b1;
      else @(negedge clk);
    end
    chk("t8_access_reached", found, 1);
    #1 rst_i = 1'b1;
    #1;
    chk("t8_rst_psel", psel_o, 0);
    chk("t8_rst_penable", penable_o, 0);
    chk("t8_rst_busy", busy_o, 0);
    chk("t8_rst_paddr", paddr_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    slv_wait = 0;
    prep();
    slv_data[0] = 32'h55; slv_data[1] = 32'h66;
    run_op(1'b1, 2'd1, 3'd1, 3'd2, 1'b0, cyc, acc, pc, dc, fp);
    chk("t8_restart_cycles", cyc, 8);
    chk("t8_restart_count", dump_n, 2);
    chk("t8_restart_d0", dump_log[0], 32'h55);
    chk("t8_restart_d1", dump_log[1], 32'h66);
    chk("t8_restart_reads", rd_cnt, 2);

    // ---- protocol / stream-gating monitors ----
    chk("apb_protocol", apb_bad, 0);
    chk("stream_gating", mode_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
